multicycle_ctrl: RTL and testbench

Multi-cycle control sequencer for the 32-bit MIPS-subset datapath: the ALU, adder, PC register, instruction register and unified memory. One instruction executes over 3–5 states. The block drives every datapath strobe and mux select and decodes ALU operations from opcode/funct. It stalls on a memory ready handshake and flags illegal opcodes and memory timeouts.

---
 rtl/ctrl_pkg.sv | 73 +++++++
 rtl/alu_op_dec.sv | 26 ++
 rtl/multicycle_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared constants for the multi-cycle MIPS-subset controller.
//   - opcode and R-type funct codes
//   - alu_op encodings driven to the ALU
//   - FSM state encoding (exported on the debug 'state' port)
//   - instruction class latched in DECODE
//   - alu_src_b / pc_src mux encodings
package ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_BRANCH = 3'd5,
        ST_JUMP   = 3'd6,
        ST_UNUSED = 3'd7
    } state_e;

    typedef enum logic [2:0] {
        CLS_R    = 3'd0,
        CLS_ADDI = 3'd1,
        CLS_LW   = 3'd2,
        CLS_SW   = 3'd3,
        CLS_BEQ  = 3'd4,
        CLS_J    = 3'd5,
        CLS_ILL  = 3'd6
    } cls_e;

    // An R-type opcode with an unsupported funct is as illegal as a bad opcode.
    function automatic cls_e classify(input logic [5:0] op, input logic funct_ok);
        cls_e c;
        case (op)
            OP_RTYPE: c = funct_ok ? CLS_R : CLS_ILL;
            OP_ADDI:  c = CLS_ADDI;
            OP_LW:    c = CLS_LW;
            OP_SW:    c = CLS_SW;
            OP_BEQ:   c = CLS_BEQ;
            OP_J:     c = CLS_J;
            default:  c = CLS_ILL;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_op_dec.sv
// alu_op_dec: R-type funct to ALU operation decoder.
//   funct  in  6  IR[5:0]
//   alu_op out 3  ALU operation code
//   valid  out 1  funct is one of the supported R-type operations
module alu_op_dec
    import ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alu_op,
    output logic       valid
);

    always_comb begin
        alu_op = ALU_ADD;
        valid  = 1'b1;
        case (funct)
            FN_ADD:  alu_op = ALU_ADD;
            FN_SUB:  alu_op = ALU_SUB;
            FN_AND:  alu_op = ALU_AND;
            FN_OR:   alu_op = ALU_OR;
            FN_SLT:  alu_op = ALU_SLT;
            default: valid  = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle control sequencer for the MIPS-subset datapath.
// Inputs : clk, rst (sync, active high), opcode, funct, alu_zero, mem_rdy.
// Outputs: memory strobes (mem_rd, mem_wr, iord), register load enables
//          (ir_we, pc_we, mdr_we, alu_out_we, reg_we), mux selects
//          (pc_src, alu_src_a, alu_src_b, reg_dst, mem_to_reg), alu_op,
//          debug state, and one-cycle error pulses illegal / mem_err.
//
// state  | meaning
// FETCH  | read instruction at PC, PC += 4 on mem_rdy
// DECODE | branch target into ALUOut, dispatch on opcode
// EXEC   | R-type ALU op or address / immediate add
// MEM    | data access for lw / sw at ALUOut
// WB     | register file write
// BRANCH | beq compare, PC <= ALUOut when equal
// JUMP   | PC <= jump target
// (7)    | unused, returns to FETCH
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int WAIT_LIMIT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       alu_zero,
    input  logic       mem_rdy,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       iord,
    output logic       ir_we,
    output logic       pc_we,
    output logic       mdr_we,
    output logic       alu_out_we,
    output logic       reg_we,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic [2:0] state,
    output logic       illegal,
    output logic       mem_err
);

    localparam int CW = $clog2(WAIT_LIMIT + 1);

    state_e        state_q, state_d;
    cls_e          cls_q, cls_d;
    logic [CW-1:0] stall_cnt_q, stall_cnt_d;

    logic [2:0] fn_alu_op;
    logic       fn_valid;
    cls_e       dec_cls;
    logic       stall;
    logic       timeout;

    alu_op_dec u_alu_op_dec (
        .funct  (funct),
        .alu_op (fn_alu_op),
        .valid  (fn_valid)
    );

    assign dec_cls = classify(opcode, fn_valid);
    assign stall   = ((state_q == ST_FETCH) || (state_q == ST_MEM)) && !mem_rdy;
    // The counter holds the stalls already seen, so the abort lands on the
    // cycle after WAIT_LIMIT stalls; a ready in that cycle still completes.
    assign timeout = stall && (stall_cnt_q == CW'(WAIT_LIMIT));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_FETCH;
            cls_q       <= CLS_ILL;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cls_q       <= cls_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        case (state_q)
            ST_FETCH: begin
                if (mem_rdy) begin
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                cls_d = dec_cls;
                case (dec_cls)
                    CLS_R, CLS_ADDI, CLS_LW, CLS_SW: state_d = ST_EXEC;
                    CLS_BEQ: state_d = ST_BRANCH;
                    CLS_J:   state_d = ST_JUMP;
                    default: state_d = ST_FETCH;
                endcase
            end
            ST_EXEC: begin
                case (cls_q)
                    CLS_R, CLS_ADDI: state_d = ST_WB;
                    CLS_LW, CLS_SW:  state_d = ST_MEM;
                    default:         state_d = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                if (mem_rdy) begin
                    state_d = (cls_q == CLS_LW) ? ST_WB : ST_FETCH;
                end else if (timeout) begin
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_FETCH;
        endcase

        // Any completion, state change or timeout restarts the count.
        stall_cnt_d = (stall && !timeout) ? stall_cnt_q + 1'b1 : '0;
    end

    always_comb begin
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        iord       = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        mdr_we     = 1'b0;
        alu_out_we = 1'b0;
        reg_we     = 1'b0;
        pc_src     = PCSRC_ALU;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_B;
        alu_op     = ALU_AND;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        state      = 3'd0;
        illegal    = 1'b0;
        mem_err    = 1'b0;
        if (!rst) begin
            state = state_q;
            case (state_q)
                ST_FETCH: begin
                    mem_rd    = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    alu_op    = ALU_ADD;
                    pc_src    = PCSRC_ALU;
                    ir_we     = mem_rdy;
                    pc_we     = mem_rdy;
                    mem_err   = timeout;
                end
                ST_DECODE: begin
                    alu_src_b  = SRCB_IMM_SH2;
                    alu_op     = ALU_ADD;
                    alu_out_we = 1'b1;
                    illegal    = (dec_cls == CLS_ILL);
                end
                ST_EXEC: begin
                    alu_src_a  = 1'b1;
                    alu_out_we = 1'b1;
                    if (cls_q == CLS_R) begin
                        alu_src_b = SRCB_B;
                        alu_op    = fn_alu_op;
                    end else begin
                        alu_src_b = SRCB_IMM;
                        alu_op    = ALU_ADD;
                    end
                end
                ST_MEM: begin
                    iord    = 1'b1;
                    mem_rd  = (cls_q == CLS_LW);
                    mem_wr  = (cls_q == CLS_SW);
                    mdr_we  = (cls_q == CLS_LW) && mem_rdy;
                    mem_err = timeout;
                end
                ST_WB: begin
                    reg_we     = 1'b1;
                    reg_dst    = (cls_q == CLS_R);
                    mem_to_reg = (cls_q == CLS_LW);
                end
                ST_BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_B;
                    alu_op    = ALU_SUB;
                    pc_src    = PCSRC_ALUOUT;
                    pc_we     = alu_zero;
                end
                ST_JUMP: begin
                    pc_src = PCSRC_JUMP;
                    pc_we  = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: self-checking bench for multicycle_ctrl.
// A hand-written cycle table covers reset and an R-type add / reset-in-MEM
// sequence; an instruction-level model then expands (opcode, funct, wait
// counts, zero flag) into the expected per-cycle outputs for directed
// corner cases and randomized instruction streams.
module tb_multicycle_ctrl;

    localparam int WAIT_LIMIT = 15;

    typedef struct packed {
        logic       mem_rd;
        logic       mem_wr;
        logic       iord;
        logic       ir_we;
        logic       pc_we;
        logic       mdr_we;
        logic       alu_out_we;
        logic       reg_we;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       reg_dst;
        logic       mem_to_reg;
        logic [2:0] state;
        logic       illegal;
        logic       mem_err;
    } outs_t;

    typedef struct {
        logic       rst;
        logic [5:0] op;
        logic [5:0] fn;
        logic       rdy;
        logic       zero;
        outs_t      exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic       alu_zero = 1'b0;
    logic       mem_rdy = 1'b0;
    logic       mem_rd, mem_wr, iord, ir_we, pc_we, mdr_we, alu_out_we, reg_we;
    logic [1:0] pc_src, alu_src_b;
    logic       alu_src_a, reg_dst, mem_to_reg, illegal, mem_err;
    logic [2:0] alu_op, state;
    outs_t      dut_o;

    int checks = 0;
    int errors = 0;
    vec_t q[$];
    vec_t tbl[11];

    always #5 clk = ~clk;

    multicycle_ctrl #(.WAIT_LIMIT(WAIT_LIMIT)) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .funct      (funct),
        .alu_zero   (alu_zero),
        .mem_rdy    (mem_rdy),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .iord       (iord),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .mdr_we     (mdr_we),
        .alu_out_we (alu_out_we),
        .reg_we     (reg_we),
        .pc_src     (pc_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .state      (state),
        .illegal    (illegal),
        .mem_err    (mem_err)
    );

    assign dut_o = {mem_rd, mem_wr, iord, ir_we, pc_we, mdr_we, alu_out_we, reg_we,
                    pc_src, alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg,
                    state, illegal, mem_err};

    // strobes = {mem_rd, mem_wr, iord, ir_we, pc_we, mdr_we, alu_out_we, reg_we}
    function automatic outs_t mk(input logic [7:0] strobes, input logic [1:0] ps,
                                 input logic a, input logic [1:0] b, input logic [2:0] op,
                                 input logic rd, input logic m2r, input logic [2:0] st,
                                 input logic il, input logic er);
        outs_t o;
        o = {strobes, ps, a, b, op, rd, m2r, st, il, er};
        return o;
    endfunction

    function automatic outs_t in_state(input logic [2:0] st);
        outs_t o;
        o = '0;
        o.state = st;
        return o;
    endfunction

    function automatic logic legal_fn(input logic [5:0] fn);
        return fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A;
    endfunction

    function automatic logic [2:0] fn_to_alu(input logic [5:0] fn);
        case (fn)
            6'h22:   return 3'b110;
            6'h24:   return 3'b000;
            6'h25:   return 3'b001;
            6'h2A:   return 3'b111;
            default: return 3'b010;
        endcase
    endfunction

    task automatic push(input logic rdy, input logic zero, input logic [5:0] op,
                        input logic [5:0] fn, input outs_t e);
        vec_t v;
        v.rst = 1'b0; v.op = op; v.fn = fn; v.rdy = rdy; v.zero = zero; v.exp = e;
        q.push_back(v);
    endtask

    // One memory state (FETCH or MEM): 'waits' stall cycles then ready,
    // unless the stall run outlasts WAIT_LIMIT, in which case mem_err aborts.
    task automatic mem_phase(input logic is_fetch, input logic lw, input logic sw,
                             input logic [5:0] op, input logic [5:0] fn,
                             input int waits, output logic ok);
        outs_t e;
        logic  rdy;
        ok = 1'b0;
        for (int k = 0; k <= WAIT_LIMIT; k++) begin
            rdy = (k >= waits);
            if (is_fetch) begin
                e = in_state(3'd0);
                e.mem_rd = 1'b1; e.alu_src_b = 2'b01; e.alu_op = 3'b010;
                e.ir_we = rdy; e.pc_we = rdy;
            end else begin
                e = in_state(3'd3);
                e.iord = 1'b1; e.mem_rd = lw; e.mem_wr = sw; e.mdr_we = lw & rdy;
            end
            e.mem_err = !rdy && (k == WAIT_LIMIT);
            if (is_fetch) push(rdy, 1'($urandom), 6'($urandom), 6'($urandom), e);
            else          push(rdy, 1'($urandom), op, fn, e);
            if (rdy) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    // Expand one instruction into its expected cycle trace.
    task automatic gen(input logic [5:0] op, input logic [5:0] fn, input int wf,
                       input int wm, input logic zero);
        outs_t e;
        logic  ok;
        logic  is_r, lw, sw, legal;
        is_r  = (op == 6'h00);
        lw    = (op == 6'h23);
        sw    = (op == 6'h2B);
        legal = (is_r && legal_fn(fn)) || op == 6'h08 || lw || sw || op == 6'h04 || op == 6'h02;
        mem_phase(1'b1, 1'b0, 1'b0, op, fn, wf, ok);
        if (!ok) return;
        e = in_state(3'd1);
        e.alu_src_b = 2'b11; e.alu_op = 3'b010; e.alu_out_we = 1'b1; e.illegal = !legal;
        push(1'($urandom), 1'($urandom), op, fn, e);
        if (!legal) return;
        if (op == 6'h04) begin
            e = in_state(3'd5);
            e.alu_src_a = 1'b1; e.alu_op = 3'b110; e.pc_src = 2'b01; e.pc_we = zero;
            push(1'($urandom), zero, op, fn, e);
            return;
        end
        if (op == 6'h02) begin
            e = in_state(3'd6);
            e.pc_src = 2'b10; e.pc_we = 1'b1;
            push(1'($urandom), 1'($urandom), op, fn, e);
            return;
        end
        e = in_state(3'd2);
        e.alu_src_a = 1'b1; e.alu_out_we = 1'b1;
        e.alu_src_b = is_r ? 2'b00 : 2'b10;
        e.alu_op    = is_r ? fn_to_alu(fn) : 3'b010;
        push(1'($urandom), 1'($urandom), op, fn, e);
        if (lw || sw) begin
            mem_phase(1'b0, lw, sw, op, fn, wm, ok);
            if (!ok || sw) return;
        end
        e = in_state(3'd4);
        e.reg_we = 1'b1; e.reg_dst = is_r; e.mem_to_reg = lw;
        push(1'($urandom), 1'($urandom), op, fn, e);
    endtask

    task automatic apply(input vec_t v, input string tag, input int idx);
        @(posedge clk);
        #1;
        rst = v.rst; opcode = v.op; funct = v.fn; mem_rdy = v.rdy; alu_zero = v.zero;
        @(negedge clk);
        checks++;
        if (dut_o !== v.exp) begin
            errors++;
            $display("FAIL %s[%0d]: outputs got %h (state %0d), expected %h (state %0d)",
                     tag, idx, dut_o, dut_o.state, v.exp, v.exp.state);
        end
    endtask

    task automatic run(input string tag);
        for (int i = 0; i < q.size(); i++) apply(q[i], tag, i);
        q.delete();
    endtask

    initial begin
        outs_t f_done, f_wait, dec, zero_o;
        logic [5:0] op_r;
        logic [5:0] fn_r;
        int         wf, wm;

        f_done = mk(8'b1001_1000, 2'b00, 1'b0, 2'b01, 3'b010, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        f_wait = mk(8'b1000_0000, 2'b00, 1'b0, 2'b01, 3'b010, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        dec    = mk(8'b0000_0010, 2'b00, 1'b0, 2'b11, 3'b010, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0);
        zero_o = '0;

        //            rst   opcode funct  rdy   zero  expected
        tbl[0]  = '{1'b1, 6'h00, 6'h20, 1'b1, 1'b0, zero_o};
        tbl[1]  = '{1'b0, 6'h00, 6'h20, 1'b1, 1'b0, f_done};
        tbl[2]  = '{1'b0, 6'h00, 6'h20, 1'b0, 1'b1, dec};
        tbl[3]  = '{1'b0, 6'h00, 6'h20, 1'b0, 1'b0,
                    mk(8'b0000_0010, 2'b00, 1'b1, 2'b00, 3'b010, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0)};
        tbl[4]  = '{1'b0, 6'h00, 6'h20, 1'b1, 1'b0,
                    mk(8'b0000_0001, 2'b00, 1'b0, 2'b00, 3'b000, 1'b1, 1'b0, 3'd4, 1'b0, 1'b0)};
        tbl[5]  = '{1'b0, 6'h2B, 6'h11, 1'b1, 1'b0, f_done};
        tbl[6]  = '{1'b0, 6'h2B, 6'h11, 1'b1, 1'b0, dec};
        tbl[7]  = '{1'b0, 6'h2B, 6'h11, 1'b1, 1'b0,
                    mk(8'b0000_0010, 2'b00, 1'b1, 2'b10, 3'b010, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0)};
        tbl[8]  = '{1'b1, 6'h2B, 6'h11, 1'b1, 1'b0, zero_o};
        tbl[9]  = '{1'b0, 6'h2B, 6'h11, 1'b0, 1'b0, f_wait};
        tbl[10] = '{1'b1, 6'h00, 6'h00, 1'b0, 1'b0, zero_o};

        for (int i = 0; i < 11; i++) apply(tbl[i], "table", i);

        gen(6'h23, 6'h00, 0, 3, 1'b0);   run("lw_wait3");
        gen(6'h04, 6'h00, 0, 0, 1'b1);   run("beq_taken");
        gen(6'h04, 6'h00, 1, 0, 1'b0);   run("beq_not_taken");
        gen(6'h02, 6'h00, 0, 0, 1'b0);   run("jump");
        gen(6'h3F, 6'h20, 0, 0, 1'b0);   run("illegal_op");
        gen(6'h00, 6'h27, 0, 0, 1'b0);   run("illegal_funct");
        gen(6'h08, 6'h00, 20, 0, 1'b0);  run("fetch_timeout");
        gen(6'h00, 6'h22, 15, 0, 1'b0);  run("fetch_rdy_at_limit");
        gen(6'h23, 6'h00, 0, 16, 1'b0);  run("mem_timeout");
        gen(6'h2B, 6'h00, 2, 15, 1'b0);  run("sw_rdy_at_limit");
        gen(6'h00, 6'h2A, 0, 0, 1'b0);   run("slt");

        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 7))
                0:       op_r = 6'h00;
                1:       op_r = 6'h08;
                2:       op_r = 6'h23;
                3:       op_r = 6'h2B;
                4:       op_r = 6'h04;
                5:       op_r = 6'h02;
                6:       op_r = 6'($urandom);
                default: op_r = 6'h00;
            endcase
            case ($urandom_range(0, 5))
                0:       fn_r = 6'h20;
                1:       fn_r = 6'h22;
                2:       fn_r = 6'h24;
                3:       fn_r = 6'h25;
                4:       fn_r = 6'h2A;
                default: fn_r = 6'($urandom);
            endcase
            wf = ($urandom_range(0, 9) == 0) ? int'($urandom_range(13, 17)) : int'($urandom_range(0, 2));
            wm = ($urandom_range(0, 9) == 0) ? int'($urandom_range(13, 17)) : int'($urandom_range(0, 2));
            gen(op_r, fn_r, wf, wm, 1'($urandom));
            run("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
